// File: rtl/background_writer.sv
// background_writer: write-side engine for the tiled background RAM (single-cell writes + clear sweep).
// Optional bounds checking on requests/clears is enabled by defining BG_BOUNDS_CHECK_EN.
`default_nettype none

module background_writer #(
   parameter int GRID_W = 64,
   parameter int GRID_H = 48,
   parameter int CELLS  = GRID_W * GRID_H,
   parameter int NUM_BG = 5,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [5:0]        req_x_i,
   input  logic [5:0]        req_y_i,
   input  logic [4:0]        req_bg_i,
   input  logic [DATA_W-1:0] req_data_i,
   input  logic              clr_start_i,
   input  logic [4:0]        clr_bg_i,
   input  logic [DATA_W-1:0] clr_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              err_o
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;
   localparam int         CNT_W   = $clog2(CELLS + 1);

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [31:0] req_addr32;
   logic [31:0] clr_base32;
   logic        req_ok;
   logic        clr_ok;
   logic        accept;

   // Same address map as the VGA read path, computed wide then truncated.
   assign req_addr32 = 32'(req_x_i) + 32'(GRID_W) * 32'(req_y_i) + 32'(CELLS) * 32'(req_bg_i);
   assign clr_base32 = 32'(CELLS) * 32'(clr_bg_i);

`ifdef BG_BOUNDS_CHECK_EN
   assign req_ok = (32'(req_x_i) < 32'(GRID_W)) && (32'(req_y_i) < 32'(GRID_H))
                   && (32'(req_bg_i) < 32'(NUM_BG));
   assign clr_ok = 32'(clr_bg_i) < 32'(NUM_BG);
`else
   assign req_ok = 1'b1;
   assign clr_ok = 1'b1;
`endif

   // Ready is forced low during reset so nothing can be accepted while it is held.
   assign req_ready_o = (state_q == S_IDLE) && !clr_start_i && !reset_i;
   assign accept      = req_valid_i && req_ready_o;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (clr_start_i && clr_ok) state_d = S_CLEAR;
         S_CLEAR: if (count_q == CNT_W'(CELLS)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d   = count_q;
      base_d    = base_q;
      fill_d    = fill_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (clr_start_i) begin
               if (clr_ok) begin
                  // Cell 0 is issued on entry, so count_q is the next cell to write.
                  base_d    = ADDR_W'(clr_base32);
                  fill_d    = clr_data_i;
                  wr_en_d   = 1'b1;
                  wr_addr_d = ADDR_W'(clr_base32);
                  wr_data_d = clr_data_i;
                  count_d   = CNT_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end else if (accept) begin
               if (req_ok) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ADDR_W'(req_addr32);
                  wr_data_d = req_data_i;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            if (count_q == CNT_W'(CELLS)) begin
               done_d  = 1'b1;
               count_d = '0;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = base_q + ADDR_W'(count_q);
               wr_data_d = fill_q;
               count_d   = count_q + CNT_W'(1);
            end
         end
         default: count_d = '0;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         count_q   <= '0;
         base_q    <= '0;
         fill_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         base_q    <= base_d;
         fill_q    <= fill_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign busy_o    = (state_q == S_CLEAR);
   assign done_o    = done_q;
   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign err_o     = err_q;

endmodule

`default_nettype wire
